// File: rtl/chimera_pkg.sv
// Shared types for the Chimera cluster power/clock gating control.
// Holds the per-cluster gate FSM state encoding and output decode.
package chimera_pkg;

   localparam int unsigned ExtClusters = 5;

   typedef enum logic [2:0] {
      CG_OFF  = 3'd0,
      CG_WAKE = 3'd1,
      CG_ON   = 3'd2,
      CG_ISO  = 3'd3,
      CG_GATE = 3'd4
   } cluster_gate_state_e;

   typedef struct packed {
      logic clk_en;
      logic rst;
      logic iso;
      logic busy;
   } cluster_gate_out_t;

   // Output levels seen by the cluster in each gate state.
   function automatic cluster_gate_out_t gate_outputs(
      input cluster_gate_state_e s,
      input logic                iso_en
   );
      cluster_gate_out_t o;
      o = '{clk_en: 1'b0, rst: 1'b1, iso: 1'b1, busy: 1'b0};
      case (s)
         CG_WAKE: o = '{clk_en: 1'b1, rst: 1'b1, iso: 1'b1, busy: 1'b1};
         CG_ON:   o = '{clk_en: 1'b1, rst: 1'b0, iso: 1'b0, busy: 1'b0};
         CG_ISO:  o = '{clk_en: 1'b1, rst: 1'b0, iso: 1'b1, busy: 1'b1};
         CG_GATE: o = '{clk_en: 1'b1, rst: 1'b1, iso: 1'b1, busy: 1'b1};
         default: o = '{clk_en: 1'b0, rst: 1'b1, iso: 1'b1, busy: 1'b0};
      endcase
      o.iso = o.iso & iso_en;
      return o;
   endfunction

endpackage

// File: rtl/chimera_cluster_gate_fsm.sv
// Power sequencing FSM for a single cluster domain.
// Wake holds reset for a fixed time, power-down waits for isolation.
module chimera_cluster_gate_fsm
   import chimera_pkg::*;
#(
   parameter int unsigned RstCycles       = 8,
   parameter int unsigned IsoTimeout      = 255,
   parameter bit          IsolateClusters = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                grant_i,
   input  logic                iso_ack_i,
   input  logic                err_clr_i,
   output logic                req_o,
   output logic                wake_o,
   output logic                clk_en_o,
   output logic                rst_o,
   output logic                isolate_o,
   output logic                busy_o,
   output logic                timeout_o,
   output cluster_gate_state_e state_o
);

   localparam int unsigned WakeW = $clog2(RstCycles);
   localparam int unsigned IsoW  = $clog2(IsoTimeout + 1);

   localparam logic [WakeW-1:0] WakeLoad = WakeW'(RstCycles - 1);
   localparam logic [IsoW-1:0]  IsoLoad  = IsoW'(IsoTimeout - 1);

   cluster_gate_state_e state_q, state_d;
   logic [WakeW-1:0]    wake_cnt_q, wake_cnt_d;
   logic [IsoW-1:0]     iso_cnt_q, iso_cnt_d;
   logic                timeout_q, timeout_d;
   logic                to_set;
   cluster_gate_out_t   out_q, out_d;

   // Next state, counters and sticky timeout flag.
   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      iso_cnt_d  = iso_cnt_q;
      to_set     = 1'b0;
      unique case (state_q)
         CG_OFF: begin
            if (en_i && grant_i) begin
               state_d    = CG_WAKE;
               wake_cnt_d = WakeLoad;
            end
         end
         CG_WAKE: begin
            if (wake_cnt_q == '0) begin
               state_d = CG_ON;
            end else begin
               wake_cnt_d = wake_cnt_q - 1'b1;
            end
         end
         CG_ON: begin
            if (!en_i) begin
               if (IsolateClusters) begin
                  state_d   = CG_ISO;
                  iso_cnt_d = IsoLoad;
               end else begin
                  state_d = CG_GATE;
               end
            end
         end
         CG_ISO: begin
            if (iso_ack_i) begin
               state_d = CG_GATE;
            end else if (iso_cnt_q == '0) begin
               state_d = CG_GATE;
               to_set  = 1'b1;
            end else begin
               iso_cnt_d = iso_cnt_q - 1'b1;
            end
         end
         CG_GATE: state_d = CG_OFF;
         default: state_d = CG_OFF;
      endcase
      timeout_d = to_set | (timeout_q & ~err_clr_i);
      out_d     = gate_outputs(state_d, IsolateClusters);
   end

   // State, counters and registered cluster outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= CG_OFF;
         wake_cnt_q <= '0;
         iso_cnt_q  <= '0;
         timeout_q  <= 1'b0;
         out_q      <= gate_outputs(CG_OFF, IsolateClusters);
      end else begin
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
         iso_cnt_q  <= iso_cnt_d;
         timeout_q  <= timeout_d;
         out_q      <= out_d;
      end
   end

   assign req_o     = (state_q == CG_OFF) && en_i;
   assign wake_o    = (state_q == CG_WAKE);
   assign clk_en_o  = out_q.clk_en;
   assign rst_o     = out_q.rst;
   assign isolate_o = out_q.iso;
   assign busy_o    = out_q.busy;
   assign timeout_o = timeout_q;
   assign state_o   = state_q;

endmodule

// File: rtl/chimera_cluster_gate_ctrl.sv
// Clock/reset/isolation gating for all Chimera cluster domains.
// Wakes are serialised by a round-robin grant to bound inrush.
module chimera_cluster_gate_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned NumClusters     = ExtClusters,
   parameter int unsigned RstCycles       = 8,
   parameter int unsigned IsoTimeout      = 255,
   parameter bit          IsolateClusters = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumClusters-1:0]   en_i,
   input  logic [NumClusters-1:0]   iso_ack_i,
   input  logic [NumClusters-1:0]   err_clr_i,
   output logic [NumClusters-1:0]   clk_en_o,
   output logic [NumClusters-1:0]   rst_o,
   output logic [NumClusters-1:0]   isolate_o,
   output logic [3*NumClusters-1:0] state_o,
   output logic [NumClusters-1:0]   timeout_o,
   output logic                     busy_o
);

   localparam int unsigned PtrW =
      (NumClusters > 1) ? $clog2(NumClusters) : 1;

   logic [NumClusters-1:0] req;
   logic [NumClusters-1:0] wake;
   logic [NumClusters-1:0] grant;
   logic [NumClusters-1:0] busy;
   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic                   found;

   cluster_gate_state_e    st [NumClusters];

   // Round-robin wake grant, only while no cluster is waking.
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      if (!(|wake)) begin
         for (int i = 0; i < int'(NumClusters); i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               ptr_d    = (i == int'(NumClusters) - 1) ? '0 : PtrW'(i + 1);
            end
         end
         for (int i = 0; i < int'(NumClusters); i++) begin
            if (!found && req[i] && (i < int'(ptr_q))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
               ptr_d    = (i == int'(NumClusters) - 1) ? '0 : PtrW'(i + 1);
            end
         end
      end
   end

   // Round-robin pointer: next index to search from.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   for (genvar g = 0; g < NumClusters; g++) begin : g_cl
      chimera_cluster_gate_fsm #(
         .RstCycles       (RstCycles),
         .IsoTimeout      (IsoTimeout),
         .IsolateClusters (IsolateClusters)
      ) u_fsm (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .en_i      (en_i[g]),
         .grant_i   (grant[g]),
         .iso_ack_i (iso_ack_i[g]),
         .err_clr_i (err_clr_i[g]),
         .req_o     (req[g]),
         .wake_o    (wake[g]),
         .clk_en_o  (clk_en_o[g]),
         .rst_o     (rst_o[g]),
         .isolate_o (isolate_o[g]),
         .busy_o    (busy[g]),
         .timeout_o (timeout_o[g]),
         .state_o   (st[g])
      );
      assign state_o[3*g +: 3] = st[g];
   end

   assign busy_o = |busy;

endmodule

// File: tb/tb_chimera_cluster_gate_ctrl.sv
// Bench for chimera_cluster_gate_ctrl: directed tables, corner
// sequences and random traffic against a timestamp-based model.
module tb_chimera_cluster_gate_ctrl;

   localparam int N  = 5;
   localparam int RC = 8;
   localparam int IT = 255;

   logic          clk;
   logic          rst;
   logic [N-1:0]  en, ack, clr;
   logic [N-1:0]  ce, ro, io, to;
   logic [3*N-1:0] st;
   logic          busy;
   logic [N-1:0]  en1, ack1, clr1;
   logic [N-1:0]  ce1, ro1, io1, to1;
   logic [3*N-1:0] st1;
   logic          busy1;

   int total = 0;
   int bad   = 0;

   chimera_cluster_gate_ctrl #(
      .NumClusters(N), .RstCycles(RC),
      .IsoTimeout(IT), .IsolateClusters(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .iso_ack_i(ack), .err_clr_i(clr),
      .clk_en_o(ce), .rst_o(ro), .isolate_o(io),
      .state_o(st), .timeout_o(to), .busy_o(busy)
   );

   chimera_cluster_gate_ctrl #(
      .NumClusters(N), .RstCycles(RC),
      .IsoTimeout(IT), .IsolateClusters(1'b0)
   ) dut_noiso (
      .clk_i(clk), .rst_i(rst), .en_i(en1),
      .iso_ack_i(ack1), .err_clr_i(clr1),
      .clk_en_o(ce1), .rst_o(ro1), .isolate_o(io1),
      .state_o(st1), .timeout_o(to1), .busy_o(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: state per cluster plus entry timestamp.
   int m_st [N];
   int m_t0 [N];
   bit m_to [N];
   int m_last;
   int m_cyc;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 0;
         m_t0[i] = 0;
         m_to[i] = 1'b0;
      end
      m_last = -1;
      m_cyc  = 0;
   endtask

   task automatic model_step();
      int ns [N];
      bit anyw;
      bit set;
      bit found;
      int idx;
      m_cyc++;
      anyw = 1'b0;
      for (int i = 0; i < N; i++) if (m_st[i] == 1) anyw = 1'b1;
      for (int i = 0; i < N; i++) begin
         ns[i] = m_st[i];
         set   = 1'b0;
         case (m_st[i])
            1: if (m_cyc - m_t0[i] == RC) ns[i] = 2;
            2: if (!en[i]) begin
                  ns[i] = 3;
                  m_t0[i] = m_cyc;
               end
            3: if (ack[i]) ns[i] = 4;
               else if (m_cyc - m_t0[i] == IT) begin
                  ns[i] = 4;
                  set = 1'b1;
               end
            4: ns[i] = 0;
            default: ;
         endcase
         if (set) m_to[i] = 1'b1;
         else if (clr[i]) m_to[i] = 1'b0;
      end
      found = 1'b0;
      if (!anyw) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_last + 1 + k) % N;
            if (!found && m_st[idx] == 0 && en[idx]) begin
               found = 1'b1;
               ns[idx] = 1;
               m_t0[idx] = m_cyc;
               m_last = idx;
            end
         end
      end
      for (int i = 0; i < N; i++) m_st[i] = ns[i];
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int fld(logic [3*N-1:0] v, int i);
      return int'(v[3*i +: 3]);
   endfunction

   task automatic check_model();
      logic [3*N-1:0] est;
      logic [N-1:0] ece, ero, eio, eto;
      logic eb;
      int s;
      int nw;
      eb = 1'b0;
      nw = 0;
      for (int i = 0; i < N; i++) begin
         s = m_st[i];
         est[3*i +: 3] = 3'(s);
         ece[i] = (s != 0);
         ero[i] = (s == 0 || s == 1 || s == 4);
         eio[i] = (s != 2);
         eto[i] = m_to[i];
         if (s == 1 || s == 3 || s == 4) eb = 1'b1;
         if (fld(st, i) == 1) nw++;
      end
      chk("model", {st, ce, ro, io, to, busy},
          {est, ece, ero, eio, eto, eb});
      chk("one_wake", 64'(nw <= 1), 64'd1);
      chk("noiso_iso_low", 64'(io1), 64'd0);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(negedge clk);
         check_model();
      end
   endtask

   task automatic do_reset();
      en = '0; ack = '0; clr = '0;
      en1 = '0; ack1 = '0; clr1 = '0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0]   en;
      logic [N-1:0]   ack;
      int             n;
      logic [3*N-1:0] st;
      logic [N-1:0]   ce, ro, io;
      logic           busy;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [$];
      int wl [N];
      int prev [N];
      int cyc;
      bit done;
      logic b44;

      model_reset();
      tbl[0] = '{5'b00101, 5'b0, 1, 15'h0001, 5'b00001, 5'b11111, 5'b11111, 1'b1};
      tbl[1] = '{5'b00101, 5'b0, 7, 15'h0001, 5'b00001, 5'b11111, 5'b11111, 1'b1};
      tbl[2] = '{5'b00101, 5'b0, 1, 15'h0002, 5'b00001, 5'b11110, 5'b11110, 1'b0};
      tbl[3] = '{5'b00101, 5'b0, 1, 15'h0042, 5'b00101, 5'b11110, 5'b11110, 1'b1};
      tbl[4] = '{5'b00101, 5'b0, 8, 15'h0082, 5'b00101, 5'b11010, 5'b11010, 1'b0};
      tbl[5] = '{5'b00100, 5'b0, 1, 15'h0083, 5'b00101, 5'b11010, 5'b11011, 1'b1};
      tbl[6] = '{5'b00100, 5'b0, 2, 15'h0083, 5'b00101, 5'b11010, 5'b11011, 1'b1};
      tbl[7] = '{5'b00100, 5'b00001, 1, 15'h0084, 5'b00101, 5'b11011, 5'b11011, 1'b1};
      tbl[8] = '{5'b00100, 5'b0, 1, 15'h0080, 5'b00100, 5'b11011, 5'b11011, 1'b0};

      // Reset values on both instances.
      en = '0; ack = '0; clr = '0;
      en1 = '0; ack1 = '0; clr1 = '0;
      rst = 1'b1;
      step(2);
      chk("rst_state", 64'(st), 64'd0);
      chk("rst_outs", {ce, ro, io, to, busy},
          {5'b0, 5'b11111, 5'b11111, 5'b0, 1'b0});
      chk("rst_outs_noiso", {ce1, ro1, io1, to1, busy1},
          {5'b0, 5'b11111, 5'b0, 5'b0, 1'b0});
      rst = 1'b0;

      // Wake serialisation and isolated power-down.
      for (int r = 0; r < 9; r++) begin
         en  = tbl[r].en;
         ack = tbl[r].ack;
         step(tbl[r].n);
         chk($sformatf("tbl%0d_state", r), 64'(st), 64'(tbl[r].st));
         chk($sformatf("tbl%0d_outs", r), {ce, ro, io, to, busy},
             {tbl[r].ce, tbl[r].ro, tbl[r].io, 5'b0, tbl[r].busy});
      end

      // Isolation timeout, sticky flag, clear, set-wins-over-clear.
      do_reset();
      en = 5'b00010;
      step(9);
      chk("t_on", 64'(fld(st, 1)), 64'd2);
      en = '0;
      step(1);
      chk("t_iso", 64'(fld(st, 1)), 64'd3);
      step(254);
      chk("t_iso_last", 64'(fld(st, 1)), 64'd3);
      chk("t_no_to_yet", 64'(to), 64'd0);
      step(1);
      chk("t_gate", 64'(fld(st, 1)), 64'd4);
      chk("t_to_set", 64'(to), 64'b00010);
      step(1);
      chk("t_off", 64'(fld(st, 1)), 64'd0);
      step(5);
      chk("t_sticky", 64'(to), 64'b00010);
      clr = 5'b00010;
      step(1);
      clr = '0;
      chk("t_clr", 64'(to), 64'd0);
      en = 5'b00010;
      step(9);
      chk("t2_on", 64'(fld(st, 1)), 64'd2);
      en = '0;
      step(255);
      chk("t2_iso_last", 64'(fld(st, 1)), 64'd3);
      clr = 5'b00010;
      step(1);
      clr = '0;
      chk("t2_gate", 64'(fld(st, 1)), 64'd4);
      chk("t2_set_wins", 64'(to), 64'b00010);
      step(1);
      chk("t2_hold", 64'(to), 64'b00010);
      clr = 5'b00010;
      step(1);
      clr = '0;
      chk("t2_clr", 64'(to), 64'd0);

      // All clusters requested from reset: grant order and timing.
      do_reset();
      en = '1;
      cyc = 0;
      done = 1'b0;
      b44 = 1'b0;
      for (int i = 0; i < N; i++) begin
         wl[i] = 0;
         prev[i] = 0;
      end
      while (!done && cyc < 100) begin
         step(1);
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (fld(st, i) == 1) begin
               wl[i]++;
               if (prev[i] != 1) order.push_back(i);
            end
            prev[i] = fld(st, i);
         end
         if (cyc == 44) b44 = busy;
         if (st == 15'h2492) done = 1'b1;
      end
      chk("all_on_reached", 64'(done), 64'd1);
      chk("all_on_cycle", 64'(cyc), 64'd45);
      chk("grant_count", 64'(order.size()), 64'd5);
      for (int k = 0; k < order.size(); k++)
         chk($sformatf("grant_order%0d", k), 64'(order[k]), 64'(k));
      for (int i = 0; i < N; i++)
         chk($sformatf("wake_len%0d", i), 64'(wl[i]), 64'(RC));
      chk("busy_before_last_on", 64'(b44), 64'd1);
      chk("busy_all_on", 64'(busy), 64'd0);

      // Bypassed isolation: straight to GATE, isolate never raised.
      do_reset();
      en1 = 5'b01000;
      step(9);
      chk("ni_on", {st1, ce1, ro1},
          {15'h0400, 5'b01000, 5'b10111});
      en1 = '0;
      step(1);
      chk("ni_gate", {st1, ce1, ro1},
          {15'h0800, 5'b01000, 5'b11111});
      step(1);
      chk("ni_off", {st1, ce1, ro1, to1},
          {15'h0000, 5'b00000, 5'b11111, 5'b0});

      // Asynchronous reset in the middle of WAKE and of ISO.
      do_reset();
      en = 5'b00001;
      step(3);
      chk("ar_in_wake", 64'(fld(st, 0)), 64'd1);
      rst = 1'b1;
      #1;
      chk("ar_wake_state", 64'(st), 64'd0);
      chk("ar_wake_outs", {ce, ro, io, to, busy},
          {5'b0, 5'b11111, 5'b11111, 5'b0, 1'b0});
      step(1);
      rst = 1'b0;
      step(9);
      chk("ar_on", 64'(fld(st, 0)), 64'd2);
      en = '0;
      step(201);
      chk("ar_in_iso", 64'(fld(st, 0)), 64'd3);
      rst = 1'b1;
      #1;
      chk("ar_iso_state", 64'(st), 64'd0);
      chk("ar_iso_outs", {ce, ro, io, to, busy},
          {5'b0, 5'b11111, 5'b11111, 5'b0, 1'b0});
      step(1);
      rst = 1'b0;
      step(300);
      chk("ar_no_timeout", {st, to}, {15'h0, 5'b0});

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(29) == 0) en[i] = ~en[i];
            ack[i] = ($urandom_range(99) == 0);
            clr[i] = ($urandom_range(49) == 0);
         end
         step(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
